// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared constants, state encoding and helpers for the
//               training sequencer (sample geometry, ROM depth, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    // Default sample geometry: pixels per sample and samples per batch
    localparam int unsigned c_N_ROWS    = 784;
    localparam int unsigned c_N_COLS    = 40;

    // Weight-ROM depth: one word per (row, col) element of a batch
    localparam int unsigned c_ROM_DEPTH = 31360;

    // Index, address and epoch field widths seen on the sequencer ports
    localparam int unsigned c_ROW_W     = 10;
    localparam int unsigned c_COL_W     = 7;
    localparam int unsigned c_ADDR_W    = 15;
    localparam int unsigned c_EPOCH_W   = 8;

    // Sequencer phases; the numeric values are visible on the phase port
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FWD  = 3'd2,
        ST_SIG  = 3'd3,
        ST_BWD  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // A request for zero epochs still runs one full pass
    function automatic logic [c_EPOCH_W-1:0] norm_epochs(input logic [c_EPOCH_W-1:0] e);
        return (e == '0) ? c_EPOCH_W'(1) : e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idx_counter2d.sv
`default_nettype none
// ============================================================================
// Module      : idx_counter2d
// Description : Two-level wrap counter over a (row, col) grid. The inner
//               (fast) dimension is selectable per cycle; clear has priority
//               over enable. Flags mark the last value of each dimension.
// Revision    : 1.0 - initial release
// ============================================================================
module idx_counter2d #(
    parameter int unsigned ROW_W  = 10,
    parameter int unsigned COL_W  = 7,
    parameter int unsigned N_ROWS = 784,
    parameter int unsigned N_COLS = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_col_inner,
    output logic [ROW_W-1:0] o_row_idx,
    output logic [COL_W-1:0] o_col_idx,
    output logic             o_row_last,
    output logic             o_col_last
);

    localparam logic [ROW_W-1:0] c_ROW_MAX = ROW_W'(N_ROWS - 1);
    localparam logic [COL_W-1:0] c_COL_MAX = COL_W'(N_COLS - 1);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_row_wrap;
    logic             w_col_wrap;

    assign w_row_wrap = (r_row == c_ROW_MAX);
    assign w_col_wrap = (r_col == c_COL_MAX);

    // Advance the inner index each enabled cycle, carrying into the outer one on wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            if (i_col_inner) begin
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= w_row_wrap ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else begin
                if (w_row_wrap) begin
                    r_row <= '0;
                    r_col <= w_col_wrap ? '0 : r_col + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end
        end
    end

    assign o_row_idx  = r_row;
    assign o_col_idx  = r_col;
    assign o_row_last = w_row_wrap;
    assign o_col_last = w_col_wrap;

endmodule
`default_nettype wire

// File: rtl/train_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : train_seq_ctrl
// Description : Training-run sequencer. Loads the weight ROM once, then runs
//               FWD / SIG / BWD passes for the requested number of epochs,
//               emitting one (row, col) work item per unstalled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module train_seq_ctrl
    import nn_pkg::*;
#(
    parameter int unsigned N_ROWS = c_N_ROWS,
    parameter int unsigned N_COLS = c_N_COLS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  epochs,
    input  logic        stall,
    output logic [2:0]  phase,
    output logic        step_vld,
    output logic [9:0]  row_idx,
    output logic [6:0]  col_idx,
    output logic [14:0] rom_addr,
    output logic        wld_en,
    output logic        acc_clr,
    output logic [7:0]  epoch_cnt,
    output logic        busy,
    output logic        done
);

    // Address offset added each time LOAD finishes a column
    localparam logic [c_ADDR_W-1:0] c_ROW_STEP = c_ADDR_W'(N_ROWS);

    state_e                r_state;
    state_e                w_next;
    logic [c_EPOCH_W-1:0]  r_epochs;
    logic [c_EPOCH_W-1:0]  r_epoch_cnt;
    logic [c_ADDR_W-1:0]   r_col_base;

    logic                  w_ctr_en;
    logic                  w_ctr_clr;
    logic                  w_col_inner;
    logic                  w_start_run;
    logic                  w_epoch_inc;
    logic                  w_work;
    logic                  w_more;
    logic                  w_last;
    logic                  w_row_last;
    logic                  w_col_last;
    logic [c_ROW_W-1:0]    w_row_idx;
    logic [c_COL_W-1:0]    w_col_idx;

    idx_counter2d #(
        .ROW_W  (c_ROW_W),
        .COL_W  (c_COL_W),
        .N_ROWS (N_ROWS),
        .N_COLS (N_COLS)
    ) u_idx (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_ctr_en),
        .i_clr       (w_ctr_clr),
        .i_col_inner (w_col_inner),
        .o_row_idx   (w_row_idx),
        .o_col_idx   (w_col_idx),
        .o_row_last  (w_row_last),
        .o_col_last  (w_col_last)
    );

    assign w_last = w_row_last & w_col_last;
    assign w_work = (r_state == ST_LOAD) || (r_state == ST_FWD) ||
                    (r_state == ST_SIG)  || (r_state == ST_BWD);
    // Another epoch follows if the count after this BWD is still below the target
    assign w_more = ({1'b0, r_epoch_cnt} + 9'd1) < {1'b0, r_epochs};

    // Phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next phase and counter control; abort overrides stall, stall freezes everything else
    always_comb begin
        w_next      = r_state;
        w_ctr_en    = 1'b0;
        w_ctr_clr   = 1'b0;
        w_col_inner = 1'b0;
        w_start_run = 1'b0;
        w_epoch_inc = 1'b0;
        if (abort) begin
            w_next    = ST_IDLE;
            w_ctr_clr = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_ctr_clr = 1'b1;
                    if (start && !stall) begin
                        w_next      = ST_LOAD;
                        w_start_run = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!stall) begin
                        if (w_last) begin
                            w_next    = ST_FWD;
                            w_ctr_clr = 1'b1;
                        end else begin
                            w_ctr_en  = 1'b1;
                        end
                    end
                end
                ST_FWD: begin
                    if (!stall) begin
                        if (w_last) begin
                            w_next    = ST_SIG;
                            w_ctr_clr = 1'b1;
                        end else begin
                            w_ctr_en  = 1'b1;
                        end
                    end
                end
                ST_SIG: begin
                    // Row stays at zero: the column wrap is also the exit point
                    w_col_inner = 1'b1;
                    if (!stall) begin
                        if (w_col_last) begin
                            w_next    = ST_BWD;
                            w_ctr_clr = 1'b1;
                        end else begin
                            w_ctr_en  = 1'b1;
                        end
                    end
                end
                ST_BWD: begin
                    w_col_inner = 1'b1;
                    if (!stall) begin
                        if (w_last) begin
                            w_ctr_clr   = 1'b1;
                            w_epoch_inc = 1'b1;
                            w_next      = w_more ? ST_FWD : ST_DONE;
                        end else begin
                            w_ctr_en    = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!stall) begin
                        w_next = ST_IDLE;
                    end
                end
                default: begin
                    w_next    = ST_IDLE;
                    w_ctr_clr = 1'b1;
                end
            endcase
        end
    end

    // Latch the epoch target at start and count completed BWD passes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epochs    <= c_EPOCH_W'(1);
            r_epoch_cnt <= '0;
        end else if (w_start_run) begin
            r_epochs    <= norm_epochs(epochs);
            r_epoch_cnt <= '0;
        end else if (w_epoch_inc) begin
            r_epoch_cnt <= r_epoch_cnt + 8'd1;
        end
    end

    // Running column offset for the ROM address; bumps by one column at each LOAD row wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_base <= '0;
        end else if (w_ctr_clr) begin
            r_col_base <= '0;
        end else if ((r_state == ST_LOAD) && w_ctr_en && w_row_last) begin
            r_col_base <= r_col_base + c_ROW_STEP;
        end
    end

    assign phase     = r_state;
    assign step_vld  = w_work & ~stall;
    assign row_idx   = w_row_idx;
    assign col_idx   = w_col_idx;
    assign rom_addr  = (r_state == ST_LOAD) ? (r_col_base + c_ADDR_W'(w_row_idx)) : '0;
    assign wld_en    = (r_state == ST_LOAD) && (w_col_idx == '0);
    assign acc_clr   = (r_state == ST_FWD) && step_vld && (w_row_idx == '0);
    assign epoch_cnt = r_epoch_cnt;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_train_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_train_seq_ctrl
// Description : Self-checking bench for train_seq_ctrl on a reduced grid.
//               A flat work-item list per run, built from the phase rules,
//               predicts every output every cycle; phase lengths and event
//               counts are also checked against closed-form totals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_train_seq_ctrl;

    localparam int R  = 17;
    localparam int C  = 5;
    localparam int RC = R * C;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  epochs;
    logic        stall;
    logic [2:0]  phase;
    logic        step_vld;
    logic [9:0]  row_idx;
    logic [6:0]  col_idx;
    logic [14:0] rom_addr;
    logic        wld_en;
    logic        acc_clr;
    logic [7:0]  epoch_cnt;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    train_seq_ctrl #(.N_ROWS(R), .N_COLS(C)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .epochs(epochs),
        .stall(stall), .phase(phase), .step_vld(step_vld), .row_idx(row_idx),
        .col_idx(col_idx), .rom_addr(rom_addr), .wld_en(wld_en), .acc_clr(acc_clr),
        .epoch_cnt(epoch_cnt), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model: one entry per unstalled cycle of a run
    typedef struct {
        int ph; int row; int col; int addr; bit wld; bit acc; int ep;
    } item_t;

    item_t plan[$];
    int    p          = 0;
    bit    running    = 0;
    bit    ep_known   = 1;
    int    exp_ep     = 0;
    int    run_epochs = 1;

    function automatic item_t mk(int ph, int row, int col, int addr, bit wld, bit acc, int ep);
        item_t it;
        it.ph = ph; it.row = row; it.col = col; it.addr = addr;
        it.wld = wld; it.acc = acc; it.ep = ep;
        return it;
    endfunction

    function automatic void build_plan(int e_in);
        int e;
        e = (e_in == 0) ? 1 : e_in;
        plan.delete();
        for (int c = 0; c < C; c++)
            for (int r = 0; r < R; r++)
                plan.push_back(mk(1, r, c, c * R + r, c == 0, 1'b0, 0));
        for (int ep = 0; ep < e; ep++) begin
            for (int c = 0; c < C; c++)
                for (int r = 0; r < R; r++)
                    plan.push_back(mk(2, r, c, 0, 1'b0, r == 0, ep));
            for (int c = 0; c < C; c++)
                plan.push_back(mk(3, 0, c, 0, 1'b0, 1'b0, ep));
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    plan.push_back(mk(4, r, c, 0, 1'b0, 1'b0, ep));
        end
        plan.push_back(mk(5, 0, 0, 0, 1'b0, 1'b0, e));
        run_epochs = e;
    endfunction

    task automatic compare_all();
        int e_ph, e_row, e_col, e_addr, e_ep;
        bit e_wld, e_acc, e_work;
        e_ph = 0; e_row = 0; e_col = 0; e_addr = 0; e_ep = exp_ep;
        e_wld = 0; e_acc = 0;
        if (running) begin
            e_ph = plan[p].ph;  e_row = plan[p].row; e_col = plan[p].col;
            e_addr = plan[p].addr; e_wld = plan[p].wld; e_acc = plan[p].acc;
            e_ep = plan[p].ep;
        end
        e_work = (e_ph >= 1) && (e_ph <= 4);
        check("phase",    phase,    e_ph);
        check("step_vld", step_vld, e_work && !stall);
        check("row_idx",  row_idx,  e_row);
        check("col_idx",  col_idx,  e_col);
        check("rom_addr", rom_addr, e_addr);
        check("wld_en",   wld_en,   e_wld);
        check("acc_clr",  acc_clr,  e_acc && !stall);
        check("busy",     busy,     running);
        check("done",     done,     e_ph == 5);
        if (running || ep_known)
            check("epoch_cnt", epoch_cnt, e_ep);
    endtask

    task automatic advance();
        if (abort) begin
            if (running) begin
                running  = 0;
                ep_known = 0;
            end
        end else if (running) begin
            if (!stall) begin
                if (plan[p].ph == 5) begin
                    running  = 0;
                    ep_known = 1;
                    exp_ep   = run_epochs;
                end else begin
                    p++;
                end
            end
        end else if (start && !stall) begin
            build_plan(int'(epochs));
            p       = 0;
            running = 1;
        end
    endtask

    // ---------------- observed-event monitor
    int cyc = 0, prev_phase = 0, obs_phase = 0;
    int n_load, n_fwd, n_done, load_entry, run_len, fwd_cycles, load_items, wld_items, first_load_addr;

    task automatic reset_mon();
        n_load = 0; n_fwd = 0; n_done = 0; load_entry = 0; run_len = 0;
        fwd_cycles = 0; load_items = 0; wld_items = 0; first_load_addr = -1;
    endtask

    task automatic monitor();
        cyc++;
        obs_phase = int'(phase);
        if (phase == 3'd1 && prev_phase != 1) begin
            n_load++;
            load_entry      = cyc;
            first_load_addr = int'(rom_addr);
        end
        if (phase == 3'd2 && prev_phase != 2) n_fwd++;
        if (phase == 3'd2) fwd_cycles++;
        if (phase == 3'd1 && step_vld) begin
            load_items++;
            if (wld_en) wld_items++;
        end
        if (done) begin
            n_done++;
            run_len = cyc - load_entry + 1;
        end
        prev_phase = int'(phase);
    endtask

    // One clock: drive at negedge, check mid-cycle, advance the model at the edge
    task automatic cycle(input bit s, input bit a, input bit st);
        @(negedge clk);
        start = s; abort = a; stall = st;
        #1;
        compare_all();
        monitor();
        @(posedge clk);
        advance();
    endtask

    task automatic model_reset();
        running = 0; ep_known = 1; exp_ep = 0; p = 0;
    endtask

    task automatic reset_async();
        @(negedge clk);
        #3;
        start = 0; abort = 0; stall = 0;
        rst = 1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic run_to_idle(input int budget, input int stall_pct);
        int n;
        bit st;
        n = 0;
        while (running && n < budget) begin
            st = ($urandom_range(99) < stall_pct) && (plan[p].ph != 5);
            cycle(1'b0, 1'b0, st);
            n++;
        end
        if (running) begin
            check("run_timeout", 1, 0);
            reset_async();
        end
    endtask

    // Run unstalled until the model is about to present item (ph, row, col)
    task automatic run_to_item(input string tag, input int ph, input int row, input int col);
        int n;
        n = 0;
        while (running && n < 5000 &&
               !(plan[p].ph == ph && plan[p].row == row && plan[p].col == col)) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        check(tag, running, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit st, ab, s, aborted;
        int n;
        rst = 1; start = 0; abort = 0; stall = 0; epochs = 8'd1;
        model_reset();
        reset_mon();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        compare_all();
        rst = 0;

        // Nothing happens after reset release until start
        repeat (4) cycle(1'b0, 1'b0, 1'b0);

        // One epoch, no stall: exact run length and LOAD address/enable coverage
        reset_mon();
        epochs = 8'd1;
        cycle(1'b1, 1'b0, 1'b0);
        run_to_idle(2000, 0);
        cycle(1'b0, 1'b0, 1'b0);
        check("A_run_len",     run_len,    3 * RC + C + 1);
        check("A_load_items",  load_items, RC);
        check("A_wld_items",   wld_items,  R);
        check("A_done_pulses", n_done,     1);
        check("A_epoch_cnt",   epoch_cnt,  1);

        // Three epochs with random stall: single LOAD, three FWD passes
        reset_mon();
        epochs = 8'd3;
        cycle(1'b1, 1'b0, 1'b0);
        run_to_idle(6000, 20);
        cycle(1'b0, 1'b0, 1'b0);
        check("B_fwd_entries",  n_fwd,     3);
        check("B_load_entries", n_load,    1);
        check("B_done_pulses",  n_done,    1);
        check("B_epoch_cnt",    epoch_cnt, 3);

        // Ten-cycle stall in the middle of FWD stretches that phase by ten
        reset_mon();
        epochs = 8'd1;
        cycle(1'b1, 1'b0, 1'b0);
        run_to_item("C_reached", 2, R / 2, 2);
        repeat (10) cycle(1'b0, 1'b0, 1'b1);
        run_to_idle(2000, 0);
        check("C_fwd_len", fwd_cycles, RC + 10);

        // Abort inside BWD: IDLE next cycle, no done, clean restart at address 0
        reset_mon();
        epochs = 8'd2;
        cycle(1'b1, 1'b0, 1'b0);
        run_to_item("D_reached", 4, 3, 2);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("D_idle_after_abort", obs_phase, 0);
        check("D_no_done", n_done, 0);
        reset_mon();
        cycle(1'b1, 1'b0, 1'b0);
        run_to_idle(3000, 10);
        check("D_restart_load", n_load, 1);
        check("D_restart_addr", first_load_addr, 0);

        // Asynchronous reset mid-SIG, then a zero-epoch request runs exactly one epoch
        reset_mon();
        epochs = 8'd2;
        cycle(1'b1, 1'b0, 1'b0);
        run_to_item("E_reached", 3, 0, 2);
        reset_async();
        reset_mon();
        epochs = 8'd0;
        cycle(1'b1, 1'b0, 1'b0);
        run_to_idle(2000, 0);
        cycle(1'b0, 1'b0, 1'b0);
        check("E_fwd_entries", n_fwd,     1);
        check("E_done_pulses", n_done,    1);
        check("E_epoch_cnt",   epoch_cnt, 1);

        // Random runs: random epochs, stalls, stray starts and occasional aborts
        for (int k = 0; k < 8; k++) begin
            reset_mon();
            epochs = 8'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0);
            aborted = 0;
            n = 0;
            while (running && n < 6000) begin
                st = ($urandom_range(99) < 25) && (plan[p].ph != 5);
                ab = ($urandom_range(0, 299) == 0) && (plan[p].ph != 5);
                s  = ($urandom_range(0, 9) == 0);
                if (ab) aborted = 1;
                cycle(s, ab, st);
                n++;
            end
            if (running) begin
                check("F_run_timeout", 1, 0);
                reset_async();
            end
            cycle(1'b0, 1'b0, 1'b0);
            check("F_done_count", n_done, aborted ? 0 : 1);
            check("F_load_entries", n_load, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/train_seq_ctrl.md
TRAIN_SEQ_CTRL -- requirements
Module: train_seq_ctrl

Interface
REQ-001 Parameter N_ROWS, default 784: input vector length (pixels per sample).
REQ-002 Parameter N_COLS, default 40: samples per batch.
REQ-003 Port clk  input  1: single clock, all state updates on rising edge.
REQ-004 Port rst  input  1: asynchronous active-high reset.
REQ-005 Port start  input  1: begin a training run; sampled only in IDLE.
REQ-006 Port abort  input  1: terminate the run and return to IDLE.
REQ-007 Port epochs  input  8: number of FWD/SIG/BWD passes; sampled at start; 0 is treated as 1.
REQ-008 Port stall  input  1: datapath not ready; freezes all counters and the FSM.
REQ-009 Port phase  output  3: encoded state (IDLE=0, LOAD=1, FWD=2, SIG=3, BWD=4, DONE=5).
REQ-010 Port step_vld  output  1: current row/col/addr are a valid work item this cycle.
REQ-011 Port row_idx  output  10, and col_idx  output  7: current element indices.
REQ-012 Port rom_addr  output  15: col_idx*N_ROWS + row_idx; valid in LOAD.
REQ-013 Port wld_en  output  1: weight-ROM load enable.
REQ-014 Port acc_clr  output  1: first term of a z accumulation (row_idx==0 in FWD).
REQ-015 Port epoch_cnt  output  8: completed epochs in this run.
REQ-016 Port busy  output  1, and done  output  1: run in progress; one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, FWD, SIG, BWD and DONE; phase SHALL equal the current state encoding.
REQ-018 IDLE SHALL move to LOAD the cycle after start=1, clear row/col/epoch_cnt, and latch epochs (0 becomes 1).
REQ-019 LOAD SHALL iterate row_idx inner (0..N_ROWS-1) and col_idx outer (0..N_COLS-1), one item per unstalled cycle; wld_en SHALL be 1 only while col_idx==0.
REQ-020 After item (N_ROWS-1, N_COLS-1), LOAD SHALL go to FWD with row/col cleared.
REQ-021 FWD SHALL use the same order as LOAD; acc_clr SHALL equal step_vld and row_idx==0; after the last item it SHALL go to SIG.
REQ-022 SIG SHALL iterate col_idx 0..N_COLS-1 with row_idx held at 0, then go to BWD.
REQ-023 BWD SHALL iterate col_idx inner and row_idx outer; after item (N_ROWS-1, N_COLS-1) it SHALL increment epoch_cnt.
REQ-024 After BWD, the FSM SHALL go to FWD if the incremented epoch_cnt is below the latched epochs, otherwise to DONE; input data SHALL not be reloaded.
REQ-025 DONE SHALL assert done for exactly one cycle, then return to IDLE; epoch_cnt SHALL hold until the next start.
REQ-026 step_vld SHALL be 1 in LOAD, FWD, SIG and BWD when stall=0, and 0 otherwise.
REQ-027 While stall=1, the FSM, counters and all outputs except step_vld SHALL hold.
REQ-028 Unstalled cycle counts SHALL be exact: LOAD 31360, FWD 31360, SIG 40, BWD 31360, DONE 1.
REQ-029 abort=1 in any state SHALL force IDLE on the next edge and clear row/col; abort SHALL take priority over stall, and done SHALL NOT pulse.
REQ-030 start in a non-IDLE state SHALL be ignored.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 rom_addr SHALL be computed with a registered running offset (add N_ROWS per column, no multiplier) and be 0 when not in LOAD.

Reset
REQ-033 rst SHALL asynchronously force IDLE with row_idx=0, col_idx=0, rom_addr=0, epoch_cnt=0, latched epochs=1, and step_vld, wld_en, acc_clr, busy and done all 0.
REQ-034 Release of rst SHALL require start before any activity begins.

Structure
REQ-035 The state encoding, N_ROWS/N_COLS defaults and the ROM depth constant 31360 SHALL live in a shared package nn_pkg.
REQ-036 One sub-module, idx_counter2d (a two-level wrap counter with selectable inner dimension, enable and clear), SHALL be instantiated once.

Verification
REQ-037 Reset then start with epochs=1 and no stall: done pulses exactly 94121 cycles after LOAD entry, with epoch_cnt=1.
REQ-038 Monitor LOAD: rom_addr steps 0..31359 with no gaps; wld_en is high for exactly the first 784 items.
REQ-039 With epochs=3: FWD is entered 3 times, LOAD only once, and epoch_cnt is 3 at done.
REQ-040 Stall at FWD (row=500, col=7) for 10 cycles: indices hold, step_vld=0, and the FWD phase lasts 31370 cycles.
REQ-041 Abort in BWD at (row=100, col=5): IDLE on the next cycle, no done pulse, and a new start restarts at LOAD with addr 0.
REQ-042 Assert rst mid-SIG, then start with epochs=0: all outputs go to reset values immediately, and the run completes one epoch.
